// File: rtl/clk_mon_pkg.sv
// Shared types for the divided-clock monitor: FSM state encoding and err_code bit positions.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } mon_state_e;

    localparam int ERR_HIGH = 0;
    localparam int ERR_LOW  = 1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, both flops reset to 1.
// Latency: 2 clk cycles. Backpressure: none.
// Compiled only when CLK_MON_SYNC_EN is defined.
`ifdef CLK_MON_SYNC_EN
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule
`endif

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures high/low/period of clk_in in clk cycles; tolerance errors, lock and stuck detection.
// Latency: edges seen 2 clk after clk_in changes (+2 with CLK_MON_SYNC_EN); results registered 1 clk after the closing rise.
// Backpressure: none; meas_valid is a single-cycle pulse that cannot be stalled.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXP_HIGH = 5,
    parameter int EXP_LOW  = 5,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 64,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_in,
    output logic [CW-1:0] high_time,
    output logic [CW-1:0] low_time,
    output logic [CW:0]   period,
    output logic          meas_valid,
    output logic [1:0]    err_code,
    output logic          locked,
    output logic          stuck
);
    localparam int            CW1      = CW + 1;
    localparam int            LW       = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);
    localparam logic [CW:0]   EXP_H_W  = CW1'(EXP_HIGH);
    localparam logic [CW:0]   EXP_L_W  = CW1'(EXP_LOW);
    localparam logic [CW:0]   TOL_W    = CW1'(TOL);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);

    logic clk_s;
`ifdef CLK_MON_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (clk_in),
        .q   (clk_s)
    );
`else
    assign clk_s = clk_in;
`endif

    // s/prev reset high so a clk_in already high at reset release is not seen as a rise
    logic s_q, prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s_q    <= clk_s;
            prev_q <= s_q;
        end
    end

    logic rise, fall;
    assign rise = s_q & ~prev_q;
    assign fall = ~s_q & prev_q;

    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise | fall) begin
            cnt <= CW'(1);
        end else if (cnt != TO_VAL) begin
            cnt <= cnt + CW'(1);
        end
    end

    logic timeout;
    assign timeout = (cnt == TO_VAL) & ~rise & ~fall;

    mon_state_e    state_q, state_d;
    logic [CW-1:0] high_ph_q, high_ph_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [CW-1:0] high_time_d, low_time_d;
    logic [CW:0]   period_d;
    logic          meas_d, locked_d, stuck_d, to_hit;
    logic [1:0]    err_d;

    // Deviation computed one bit wider so |meas - exp| never wraps
    logic [CW:0] high_w, low_w, dev_h, dev_l;
    assign high_w = {1'b0, high_ph_q};
    assign low_w  = {1'b0, cnt};
    assign dev_h  = (high_w >= EXP_H_W) ? (high_w - EXP_H_W) : (EXP_H_W - high_w);
    assign dev_l  = (low_w >= EXP_L_W) ? (low_w - EXP_L_W) : (EXP_L_W - low_w);

    always_comb begin
        state_d     = state_q;
        high_ph_d   = high_ph_q;
        lock_d      = lock_q;
        high_time_d = high_time;
        low_time_d  = low_time;
        period_d    = period;
        meas_d      = 1'b0;
        err_d       = 2'b00;
        locked_d    = locked;
        stuck_d     = stuck;
        to_hit      = 1'b0;

        if (rise) begin
            stuck_d = 1'b0;
        end

        case (state_q)
            S_WAIT: begin
                if (rise) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (fall) begin
                    high_ph_d = cnt;
                    state_d   = S_LOW;
                end else if (timeout) begin
                    to_hit = 1'b1;
                end
            end
            S_LOW: begin
                if (rise) begin
                    high_time_d     = high_ph_q;
                    low_time_d      = cnt;
                    period_d        = high_w + low_w;
                    meas_d          = 1'b1;
                    err_d[ERR_HIGH] = (dev_h > TOL_W);
                    err_d[ERR_LOW]  = (dev_l > TOL_W);
                    if (err_d != 2'b00) begin
                        lock_d = '0;
                    end else if (lock_q != LOCK_MAX) begin
                        lock_d = lock_q + LW'(1);
                    end
                    locked_d = (lock_d == LOCK_MAX);
                    state_d  = S_HIGH;
                end else if (timeout) begin
                    to_hit = 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase

        if (to_hit) begin
            stuck_d  = 1'b1;
            lock_d   = '0;
            locked_d = 1'b0;
            state_d  = S_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_WAIT;
            high_ph_q  <= '0;
            lock_q     <= '0;
            high_time  <= '0;
            low_time   <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            err_code   <= 2'b00;
            locked     <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_ph_q  <= high_ph_d;
            lock_q     <= lock_d;
            high_time  <= high_time_d;
            low_time   <= low_time_d;
            period     <= period_d;
            meas_valid <= meas_d;
            err_code   <= err_d;
            locked     <= locked_d;
            stuck      <= stuck_d;
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: drives clk_in as a list of phases and predicts measurements phase-by-phase.
module tb_clk_div_monitor;
    localparam int TIMEOUT = 64;
    localparam int EXP     = 5;
    localparam int LOCKN   = 4;

    logic       clk = 1'b0;
    logic       rst, clk_in;
    logic [7:0] high_time, low_time, high_time1, low_time1;
    logic [8:0] period, period1;
    logic       meas_valid, meas_valid1, locked, locked1, stuck, stuck1;
    logic [1:0] err_code, err_code1;

    clk_div_monitor dut (
        .clk(clk), .rst(rst), .clk_in(clk_in),
        .high_time(high_time), .low_time(low_time), .period(period),
        .meas_valid(meas_valid), .err_code(err_code), .locked(locked), .stuck(stuck)
    );

    clk_div_monitor #(.TOL(1)) dut_t1 (
        .clk(clk), .rst(rst), .clk_in(clk_in),
        .high_time(high_time1), .low_time(low_time1), .period(period1),
        .meas_valid(meas_valid1), .err_code(err_code1), .locked(locked1), .stuck(stuck1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] h;
        logic [31:0] l;
        logic [31:0] p;
        logic [31:0] err;
        logic [31:0] lk;
    } rec_t;

    rec_t act_q[$], exp_q[$], act1_q[$], exp1_q[$];
    int   st_set_act[$], st_set_exp[$], st_clr_act[$], st_clr_exp[$];
    int   err_stray = 0;
    int   lk_at_stuck = 0;
    logic stuck_q = 1'b0;

    // Observed side: everything the DUTs report, stamped with the cycle it was seen
    always @(negedge clk) begin
        if (meas_valid)
            act_q.push_back('{32'(cyc), 32'(high_time), 32'(low_time), 32'(period),
                              32'(err_code), 32'(locked)});
        if (meas_valid1)
            act1_q.push_back('{32'(cyc), 32'(high_time1), 32'(low_time1), 32'(period1),
                               32'(err_code1), 32'(locked1)});
        if (!meas_valid && err_code != 2'b00) err_stray = err_stray + 1;
        if (!meas_valid1 && err_code1 != 2'b00) err_stray = err_stray + 1;
        if (stuck && !stuck_q) begin
            st_set_act.push_back(cyc);
            if (locked) lk_at_stuck = lk_at_stuck + 1;
        end
        if (!stuck && stuck_q) st_clr_act.push_back(cyc);
        stuck_q <= stuck;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) passes = passes + 1;
        else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model state, advanced once per clk_in phase
    logic cur_lvl;
    int   cur_len, m_h, m_lk, m_lk1;
    bit   m_armed, m_stuck;

    function automatic int dev(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_meas(input int h, input int l, input int c);
        int e0, e1;
        e0 = ((dev(h, EXP) > 0) ? 1 : 0) + ((dev(l, EXP) > 0) ? 2 : 0);
        e1 = ((dev(h, EXP) > 1) ? 1 : 0) + ((dev(l, EXP) > 1) ? 2 : 0);
        m_lk  = (e0 != 0) ? 0 : ((m_lk < LOCKN) ? m_lk + 1 : LOCKN);
        m_lk1 = (e1 != 0) ? 0 : ((m_lk1 < LOCKN) ? m_lk1 + 1 : LOCKN);
        exp_q.push_back('{32'(c), 32'(h), 32'(l), 32'(h + l), 32'(e0), 32'(m_lk == LOCKN)});
        exp1_q.push_back('{32'(c), 32'(h), 32'(l), 32'(h + l), 32'(e1), 32'(m_lk1 == LOCKN)});
    endtask

    task automatic model_edge(input logic lvl, input int n, input int c0);
        if (lvl && !cur_lvl) begin
            if (m_stuck) begin
                st_clr_exp.push_back(c0 + 2);
                m_stuck = 1'b0;
            end
            if (m_armed && m_h >= 0) model_meas(m_h, cur_len, c0 + 2);
            m_armed = 1'b1;
            m_h     = -1;
        end else if (!lvl && cur_lvl && m_armed) begin
            m_h = cur_len;
        end
        if (m_armed && n > TIMEOUT) begin
            m_armed = 1'b0;
            m_h     = -1;
            m_lk    = 0;
            m_lk1   = 0;
            m_stuck = 1'b1;
            st_set_exp.push_back(c0 + TIMEOUT + 2);
        end
        cur_lvl = lvl;
        cur_len = n;
    endtask

    task automatic phase(input logic lvl, input int n);
        model_edge(lvl, n, cyc);
        clk_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic period_hl(input int h, input int l);
        phase(1'b1, h);
        phase(1'b0, l);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " high_time"}, 32'(high_time), 0);
        chk({tag, " low_time"}, 32'(low_time), 0);
        chk({tag, " period"}, 32'(period), 0);
        chk({tag, " meas_valid"}, 32'(meas_valid), 0);
        chk({tag, " err_code"}, 32'(err_code), 0);
        chk({tag, " locked"}, 32'(locked), 0);
        chk({tag, " stuck"}, 32'(stuck), 0);
    endtask

    // Low phase with a one-cycle reset pulse k cycles in (monitor is in its low phase then)
    task automatic phase_rst(input int n, input int k);
        model_edge(1'b0, n, cyc);
        clk_in = 1'b0;
        repeat (k) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("mid_reset");
        rst     = 1'b0;
        m_armed = 1'b0;
        m_h     = -1;
        m_lk    = 0;
        m_lk1   = 0;
        repeat (n - k - 1) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        rec_t a, e;
        chk({tag, " meas count"}, 32'(act_q.size()), 32'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, " meas cycle"}, a.cyc, e.cyc);
            chk({tag, " high_time"}, a.h, e.h);
            chk({tag, " low_time"}, a.l, e.l);
            chk({tag, " period"}, a.p, e.p);
            chk({tag, " err_code"}, a.err, e.err);
            chk({tag, " locked"}, a.lk, e.lk);
        end
        act_q.delete();
        exp_q.delete();
        chk({tag, " tol1 count"}, 32'(act1_q.size()), 32'(exp1_q.size()));
        while (act1_q.size() > 0 && exp1_q.size() > 0) begin
            a = act1_q.pop_front();
            e = exp1_q.pop_front();
            chk({tag, " tol1 err_code"}, a.err, e.err);
            chk({tag, " tol1 locked"}, a.lk, e.lk);
        end
        act1_q.delete();
        exp1_q.delete();
        chk({tag, " stuck set count"}, 32'(st_set_act.size()), 32'(st_set_exp.size()));
        while (st_set_act.size() > 0 && st_set_exp.size() > 0)
            chk({tag, " stuck set cycle"}, 32'(st_set_act.pop_front()), 32'(st_set_exp.pop_front()));
        st_set_act.delete();
        st_set_exp.delete();
        chk({tag, " stuck clr count"}, 32'(st_clr_act.size()), 32'(st_clr_exp.size()));
        while (st_clr_act.size() > 0 && st_clr_exp.size() > 0)
            chk({tag, " stuck clr cycle"}, 32'(st_clr_act.pop_front()), 32'(st_clr_exp.pop_front()));
        st_clr_act.delete();
        st_clr_exp.delete();
    endtask

    initial begin
        int h, l;
        rst     = 1'b1;
        clk_in  = 1'b1;
        cur_lvl = 1'b1;
        cur_len = 0;
        m_armed = 1'b0;
        m_stuck = 1'b0;
        m_h     = -1;
        m_lk    = 0;
        m_lk1   = 0;
        repeat (5) @(negedge clk);
        chk_zero("reset");
        repeat (5) @(negedge clk);
        rst = 1'b0;

        // clk_in high at release: needs low -> high -> low -> high before the first result
        phase(1'b0, 5);
        repeat (8) period_hl(5, 5);
        phase(1'b1, 5);
        compare_all("div10");

        phase(1'b0, 5);
        repeat (6) period_hl(6, 4);
        phase(1'b1, 5);
        compare_all("6h4l");

        phase(1'b0, 5);
        repeat (5) period_hl(5, 5);
        period_hl(7, 5);
        repeat (5) period_hl(5, 5);
        phase(1'b1, 5);
        compare_all("glitch");

        phase(1'b0, 5);
        phase(1'b1, 70);
        phase(1'b0, 5);
        repeat (6) period_hl(5, 5);
        phase(1'b1, 5);
        compare_all("stuck_high");

        phase(1'b0, 1);
        period_hl(1, 1);
        period_hl(64, 5);
        phase(1'b1, 5);
        phase(1'b0, 65);
        repeat (3) period_hl(5, 5);
        phase(1'b1, 5);
        compare_all("bounds");

        phase(1'b0, 5);
        repeat (3) period_hl(5, 5);
        phase(1'b1, 5);
        phase_rst(8, 3);
        repeat (6) period_hl(5, 5);
        phase(1'b1, 5);
        compare_all("mid_reset");

        phase(1'b0, 5);
        repeat (40) begin
            if ($urandom_range(0, 3) != 0) begin
                h = 5;
                l = 5;
            end else begin
                h = $urandom_range(1, 9);
                l = $urandom_range(1, 9);
            end
            period_hl(h, l);
        end
        phase(1'b1, 5);
        compare_all("random");

        chk("err_code outside meas_valid", 32'(err_stray), 0);
        chk("locked while stuck", 32'(lk_at_stuck), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
